// File: rtl/conway_frame_reader_if.sv
// conway_frame_reader_if: grid capture, row stream and population bundle
interface conway_frame_reader_if #(
    parameter int N = 16
) ();
    localparam int RW = $clog2(N);
    localparam int PW = $clog2(N * N + 1);

    logic [N*N-1:0] cells;
    logic           snap;
    logic           busy;
    logic           row_valid;
    logic           row_ready;
    logic [N-1:0]   row_data;
    logic [RW-1:0]  row_idx;
    logic           row_last;
    logic           pop_valid;
    logic [PW-1:0]  pop_count;
    logic [7:0]     frame_id;

    modport master (
        input  cells, snap, row_ready,
        output busy, row_valid, row_data, row_idx, row_last, pop_valid, pop_count, frame_id
    );

    modport slave (
        output cells, snap, row_ready,
        input  busy, row_valid, row_data, row_idx, row_last, pop_valid, pop_count, frame_id
    );
endinterface

// File: rtl/conway_frame_reader.sv
// conway_frame_reader: snapshots the grid and streams it row by row with a population count
module conway_frame_reader #(
    parameter int N = 16
) (
    input logic                     clk,
    input logic                     reset,
    conway_frame_reader_if.master   bus
);
    localparam int RW = $clog2(N);
    localparam int PW = $clog2(N * N + 1);

    typedef enum logic [1:0] {IDLE, SEND, POP} state_t;

    state_t         state_q;
    logic [N*N-1:0] snap_q;
    logic [RW-1:0]  row_q;
    logic [PW-1:0]  acc_q;
    logic [PW-1:0]  acc_d;
    logic [PW-1:0]  pop_count_q;
    logic [7:0]     frame_id_q;
    logic           row_valid_q;
    logic           pop_valid_q;
    logic           busy_q;
    logic [N-1:0]   row_d;

    // Current snapshot row and the running total including it
    always_comb begin
        row_d = snap_q[int'(row_q)*N +: N];
        acc_d = acc_q;
        for (int j = 0; j < N; j++) acc_d = acc_d + PW'(row_d[j]);
    end

    // Frame FSM: capture in IDLE, drain rows in SEND, publish the count in POP
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            row_q       <= '0;
            acc_q       <= '0;
            pop_count_q <= '0;
            frame_id_q  <= '0;
            row_valid_q <= 1'b0;
            pop_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.snap) begin
                    snap_q      <= bus.cells;
                    row_q       <= '0;
                    acc_q       <= '0;
                    row_valid_q <= 1'b1;
                    busy_q      <= 1'b1;
                    state_q     <= SEND;
                end
                SEND: if (bus.row_ready) begin
                    acc_q <= acc_d;
                    if (row_q == RW'(N - 1)) begin
                        row_q       <= '0;
                        row_valid_q <= 1'b0;
                        pop_valid_q <= 1'b1;
                        pop_count_q <= acc_d;
                        state_q     <= POP;
                    end else begin
                        row_q <= row_q + RW'(1);
                    end
                end
                POP: begin
                    pop_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    frame_id_q  <= frame_id_q + 8'd1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.row_valid = row_valid_q;
    assign bus.row_data  = row_valid_q ? row_d : '0;
    assign bus.row_idx   = row_q;
    assign bus.row_last  = row_valid_q && (row_q == RW'(N - 1));
    assign bus.pop_valid = pop_valid_q;
    assign bus.pop_count = pop_count_q;
    assign bus.frame_id  = frame_id_q;
endmodule

// File: tb/tb_conway_frame_reader.sv
// tb_conway_frame_reader: randomized scoreboard bench against a frame-level reference model
module tb_conway_frame_reader;
    localparam int N  = 16;
    localparam int RW = $clog2(N);
    localparam int PW = $clog2(N * N + 1);

    typedef struct packed {
        logic [N-1:0]  d;
        logic [RW-1:0] i;
        logic          l;
    } beat_t;

    typedef struct packed {
        logic [PW-1:0] c;
        logic [7:0]    f;
    } pop_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    beat_t         rq[$];
    pop_t          pq[$];
    int            m_left = 0;
    bit            m_pop = 1'b0;
    int            m_fid = 0;
    logic [PW-1:0] m_pc = '0;
    logic [PW-1:0] m_pend = '0;
    bit            m_live = 1'b0;
    logic [7:0]    fid0;

    conway_frame_reader_if #(.N(N)) bus ();
    conway_frame_reader #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*N-1:0] rnd_cells();
        logic [N*N-1:0] c;
        int dens = $urandom_range(1, 7);
        for (int k = 0; k < N * N; k++) c[k] = ($urandom_range(0, 7) < dens);
        return c;
    endfunction

    // Reference model: a frame is N accepted rows followed by one pop cycle
    always @(posedge clk) begin
        if (!reset) begin
            rq.delete();
            pq.delete();
            m_left = 0;
            m_pop  = 1'b0;
            m_fid  = 0;
            m_pc   = '0;
            m_live = 1'b1;
        end else if (m_pop) begin
            m_pop = 1'b0;
            m_fid = (m_fid + 1) % 256;
        end else if (m_left > 0) begin
            if (bus.row_ready) begin
                m_left--;
                if (m_left == 0) begin
                    m_pop = 1'b1;
                    m_pc  = m_pend;
                end
            end
        end else if (bus.snap) begin
            for (int k = 0; k < N; k++)
                rq.push_back('{d: bus.cells[k*N +: N], i: RW'(k), l: (k == N - 1)});
            m_pend = PW'($countones(bus.cells));
            pq.push_back('{c: m_pend, f: 8'(m_fid)});
            m_left = N;
        end
    end

    // Monitor: compares presented beats and pop pulses against the queues
    always @(negedge clk) begin
        if (m_live) begin
            chk("row_valid", 64'(bus.row_valid), 64'(m_left > 0));
            chk("pop_valid", 64'(bus.pop_valid), 64'(m_pop));
            chk("busy", 64'(bus.busy), 64'(m_left > 0 || m_pop));
            chk("pop_count_hold", 64'(bus.pop_count), 64'(m_pc));
            chk("frame_id", 64'(bus.frame_id), 64'(m_fid));
            if (bus.row_valid) begin
                if (rq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL row_extra: got row %0h idx %0d want no beat", bus.row_data, bus.row_idx);
                end else begin
                    chk("row_data", 64'(bus.row_data), 64'(rq[0].d));
                    chk("row_idx", 64'(bus.row_idx), 64'(rq[0].i));
                    chk("row_last", 64'(bus.row_last), 64'(rq[0].l));
                    if (bus.row_ready) void'(rq.pop_front());
                end
            end
            if (bus.pop_valid) begin
                if (pq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_extra: got count %0d want no pop", bus.pop_count);
                end else begin
                    chk("pop_count", 64'(bus.pop_count), 64'(pq[0].c));
                    chk("pop_frame_id", 64'(bus.frame_id), 64'(pq[0].f));
                    void'(pq.pop_front());
                end
            end
        end
    end

    // mode 0: ready high, 1: ready 0,0,1, 2: random ready, 3: ready high with stray snaps
    task automatic frame(input logic [N*N-1:0] c, input int mode);
        int n = 0;
        bus.cells = c;
        bus.snap = 1'b1;
        bus.row_ready = 1'b1;
        tick();
        bus.snap = 1'b0;
        bus.cells = ~c;
        while ((m_left > 0 || m_pop) && n < 400) begin
            bus.row_ready = (mode == 1) ? (n % 3 == 2) : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.snap = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            n++;
        end
        bus.snap = 1'b0;
        chk("frame_done", 64'(n < 400), 64'(1));
    endtask

    initial begin
        reset = 1'b0;
        bus.snap = 1'b0;
        bus.row_ready = 1'b0;
        bus.cells = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("rst_row_data", 64'(bus.row_data), 64'(0));
        chk("rst_row_idx", 64'(bus.row_idx), 64'(0));
        chk("rst_row_last", 64'(bus.row_last), 64'(0));

        bus.cells = rnd_cells();
        bus.snap = 1'b1;
        tick();
        bus.snap = 1'b0;
        bus.row_ready = 1'b1;
        repeat (2) tick();
        bus.row_ready = 1'b0;
        repeat (3) tick();
        chk("abort_wait_idx", 64'(bus.row_idx), 64'(2));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_valid", 64'(bus.row_valid), 64'(0));
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_data", 64'(bus.row_data), 64'(0));
        chk("abort_idx", 64'(bus.row_idx), 64'(0));
        chk("abort_last", 64'(bus.row_last), 64'(0));
        chk("abort_pop", 64'(bus.pop_valid), 64'(0));
        chk("abort_count", 64'(bus.pop_count), 64'(0));
        chk("abort_fid", 64'(bus.frame_id), 64'(0));
        tick();

        frame('1, 0);
        chk("all_ones_count", 64'(bus.pop_count), 64'(N * N));
        frame('0, 0);
        chk("zero_count", 64'(bus.pop_count), 64'(0));
        frame(rnd_cells(), 1);
        frame(rnd_cells(), 3);
        repeat (12) frame(rnd_cells(), $urandom_range(0, 3));

        fid0 = 8'(m_fid);
        bus.cells = rnd_cells();
        bus.snap = 1'b1;
        bus.row_ready = 1'b1;
        repeat (256 * (N + 2)) begin
            tick();
            bus.cells = ~bus.cells;
        end
        bus.snap = 1'b0;
        tick();
        chk("wrap_fid", 64'(bus.frame_id), 64'(fid0));
        chk("wrap_idle", 64'(bus.busy), 64'(0));

        repeat (3) tick();
        chk("rows_drained", 64'(rq.size()), 64'(0));
        chk("pops_drained", 64'(pq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conway_frame_reader.md
# conway_frame_reader

Readout end of the Conway grid. It captures the `N*N` `cells` vector produced by the grid in a single cycle and streams the snapshot out one row per beat over a valid/ready interface. It also reports the frame's live-cell population and a wrapping frame counter. It sits between the grid and any display or host link, so the grid keeps evolving while a consistent frame drains at the consumer's pace.

## Interface
- `N`, 16, grid edge length; must match the grid instance. Row index width `RW = $clog2(N)`; population width `PW = $clog2(N*N+1)`.

- `clk`  in  1  sole clock; everything updates on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clk`.
- `cells`  in  N*N  live grid state; bit `i*N+j` is row `i`, column `j`.
- `snap`  in  1  snapshot request; only acted on in IDLE.
- `busy`  out  1  high in SEND and POP.
- `row_valid`  out  1  a row beat is presented.
- `row_ready`  in  1  consumer accepts the beat.
- `row_data`  out  N  snapshot row; bit `j` = column `j`.
- `row_idx`  out  RW  index of the presented row.
- `row_last`  out  1  high with row `N-1`.
- `pop_valid`  out  1  one-cycle pulse when the frame's population is final.
- `pop_count`  out  PW  live cells in the frame just sent.
- `frame_id`  out  8  completed-frame counter; wraps 255→0.

## Operation
- FSM states:
  - IDLE: `snap`=1 latches `cells` into an internal `N*N` snapshot register, clears the row counter and accumulator, then moves to SEND.
  - SEND: presents row `row_idx` of the snapshot. A handshake is `row_valid & row_ready` at a clock edge. Each handshake adds the popcount of `row_data` to the accumulator and increments the row counter. The handshake on row `N-1` moves the FSM to POP.
  - POP: lasts exactly 1 cycle. `pop_valid`=1, `pop_count` = final accumulator, `frame_id` increments at the exit edge. Then returns to IDLE.
- `row_data = snapshot[row_idx*N +: N]`.
- Later changes on `cells` never affect a frame in flight.
- `row_valid` is high for the whole of SEND.
  - `row_data`, `row_idx` and `row_last` stay stable while `row_valid & !row_ready`.
  - `row_valid` never drops without a handshake.
- `snap` is ignored in SEND and POP. It is not queued.
- `snap` held high in IDLE starts a frame on that edge. If it stays high, the next frame starts in the IDLE cycle after POP.
- Arithmetic:
  - The accumulator is `PW` bits and cannot overflow, since the maximum is `N*N`.
  - The row counter is `RW` bits and is never incremented past `N-1`.
- `pop_count` holds its last value after POP until the next POP. It is cleared only by reset.

## Timing
- Reset (`reset`=0 at an edge): state IDLE. All outputs become 0: `busy`, `row_valid`, `row_data`, `row_idx`, `row_last`, `pop_valid`, `pop_count`, `frame_id`. The snapshot register and accumulator are cleared.
- Reset mid-frame aborts the frame. `frame_id` does not advance. The next frame restarts at row 0.
- `snap` sampled at edge t (IDLE) → `row_valid`=1 and row 0 on the outputs from edge t (visible in cycle t+1).
- Row `k` accepted at edge u → row `k+1` presented in cycle u+1, with no bubble.
- Last row accepted at edge u → cycle u+1 is POP (`pop_valid`=1, `row_valid`=0) → IDLE in cycle u+2, and `frame_id` has advanced.
- Minimum frame length with `row_ready` tied high: `N` SEND cycles + 1 POP cycle. The earliest next snapshot is sampled in cycle N+2 after the first.
- `busy` equals `row_valid | pop_valid`.

## Test plan
- Bench at `N`=4, `row_ready`=1, `cells`=16'hF0A1, single `snap` pulse:
  - rows 4'h1, 4'hA, 4'h0, 4'hF with `row_idx` 0..3;
  - `row_last` only on row 3;
  - then `pop_valid` pulse with `pop_count`=7, `frame_id` 0→1.
- Snapshot isolation: as above, but `cells` changes to 16'h0000 the cycle after `snap` → the identical four rows and `pop_count`=7 are still delivered.
- Backpressure: `row_ready` toggles 0,0,1 repeatedly → each row is held stable for 3 cycles, no row is lost or duplicated, and `pop_count` is unchanged.
- `snap` pulses during SEND and POP → ignored, exactly one frame is emitted. `snap` held high → back-to-back frames with one IDLE cycle between POP and the next row 0.
- Boundary values:
  - `cells`=all-ones (`N`=16) → `pop_count`=256.
  - `cells`=0 → `pop_count`=0.
  - 256 frames → `frame_id` wraps to 0.
- `reset`=0 asserted while row 2 is awaiting `row_ready` → next cycle all outputs are 0, state IDLE, `frame_id` unchanged from its pre-frame value. A new `snap` then restarts at row 0.
